// File: rtl/network_request_port.sv
// network_request_port: turns core loads/stores into mesh request packets and waits for read replies
module network_request_port #(
  parameter int DATA_WIDTH               = 6,
  parameter int NETWORK_ADDRESS_WIDTH    = 4,
  parameter int CACHE_BANK_ADDRESS_WIDTH = 3,
  parameter int TIMEOUT_CYCLES           = 32
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]                       localAddress,
  input  logic                                                   req_valid,
  output logic                                                   req_ready,
  input  logic                                                   req_write,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]                                  req_data,
  output logic                                                   resp_valid,
  output logic [DATA_WIDTH-1:0]                                  resp_data,
  output logic                                                   resp_error,
  output logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]                       requesterAddressOut,
  output logic                                                   readOut,
  output logic                                                   writeOut,
  output logic [DATA_WIDTH-1:0]                                  dataOut,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]                       requesterAddressIn,
  input  logic                                                   readIn,
  input  logic                                                   writeIn,
  input  logic [DATA_WIDTH-1:0]                                  dataIn,
  output logic [7:0]                                             drop_count
);
  localparam int AW = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

  state_t                           r_state, w_next;
  logic [CW-1:0]                    r_count;
  logic                             r_req_ready, r_resp_valid, r_resp_error, r_rd, r_wr;
  logic [DATA_WIDTH-1:0]            r_resp_data, r_dout;
  logic [AW-1:0]                    r_dst;
  logic [NETWORK_ADDRESS_WIDTH-1:0] r_reqr;
  logic [7:0]                       r_drop;
  logic                             w_accept, w_for_me, w_consume, w_expire, w_drop, w_unused;

  assign w_accept  = r_req_ready & req_valid;
  assign w_for_me  = destinationAddressIn[AW-1 -: NETWORK_ADDRESS_WIDTH] == localAddress;
  assign w_consume = (r_state == WAIT) & writeIn & ~readIn & w_for_me;
  assign w_expire  = r_count == LAST;
  assign w_drop    = (readIn | writeIn) & w_for_me & ~w_consume;
  assign w_unused  = ^{requesterAddressIn, destinationAddressIn[CACHE_BANK_ADDRESS_WIDTH-1:0]};

  // next-state decode; a reply takes priority over timeout expiry
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? SEND : IDLE;
      SEND:    w_next = r_wr ? IDLE : WAIT;
      WAIT:    w_next = (w_consume | w_expire) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end

  // state, ready flag and reply-wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= w_next == IDLE;
      r_count     <= (r_state == WAIT) ? r_count + CW'(1) : '0;
    end
  end

  // packet fields are loaded on acceptance so they are visible only during SEND
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dst  <= '0;
      r_reqr <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_dout <= '0;
    end else begin
      r_dst  <= w_accept ? req_addr : '0;
      r_reqr <= w_accept ? localAddress : '0;
      r_rd   <= w_accept & ~req_write;
      r_wr   <= w_accept & req_write;
      r_dout <= (w_accept & req_write) ? req_data : '0;
    end
  end

  // one-cycle load completion carrying reply data or a timeout error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_next == RESP;
      r_resp_error <= (r_state == WAIT) & ~w_consume & w_expire;
      r_resp_data  <= w_consume ? dataIn : '0;
    end
  end

  // saturating count of local packets that were not consumed as replies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_drop <= '0;
    else        r_drop <= r_drop + 8'(w_drop && r_drop != 8'hFF);
  end

  assign req_ready             = r_req_ready;
  assign resp_valid            = r_resp_valid;
  assign resp_data             = r_resp_data;
  assign resp_error            = r_resp_error;
  assign destinationAddressOut = r_dst;
  assign requesterAddressOut   = r_reqr;
  assign readOut               = r_rd;
  assign writeOut              = r_wr;
  assign dataOut               = r_dout;
  assign drop_count            = r_drop;
endmodule

// File: doc/network_request_port.md
# network_request_port

Core-side initiator endpoint for the 2D-mesh cache network. It accepts load/store commands from a local requester, formats them into single-cycle request packets driven into one router port, and waits for the matching read reply from the network. Read replies are returned to the requester, and a read with no reply within a bounded window completes with an error. The block sits between a core (or test driver) and the router port that the mesh exposes for request injection.

## Interface
- DATA_WIDTH, 6: payload width.
- NETWORK_ADDRESS_WIDTH, 4: router address width (row+column).
- CACHE_BANK_ADDRESS_WIDTH, 3: line address within a bank.
- TIMEOUT_CYCLES, 32: maximum cycles spent waiting for a read reply; minimum 2.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- localAddress  in  NETWORK_ADDRESS_WIDTH  this endpoint's network address; static.
- req_valid  in  1  core command valid.
- req_ready  out  1  block can accept a command.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH  {node, line}.
- req_data  in  DATA_WIDTH  store data.
- resp_valid  out  1  one-cycle load completion.
- resp_data  out  DATA_WIDTH  load data.
- resp_error  out  1  qualifies resp_valid; 1 = timeout.
- destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut  out  packet fields (widths as above)  request packet to the router.
- destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn  in  packet fields  packets delivered from the router.
- drop_count  out  8  saturating count of discarded inbound packets.

## Operation
- FSM states: IDLE, SEND, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, latch write/addr/data and go to SEND.
- SEND (one cycle): destinationAddressOut=latched addr, requesterAddressOut=localAddress, dataOut=latched data (0 for loads), readOut=~write, writeOut=write. Stores then go to IDLE; they are posted and produce no response. Loads go to WAIT with the timeout counter cleared.
- WAIT: a reply is any inbound packet with writeIn=1, readIn=0, and destinationAddressIn[top NETWORK_ADDRESS_WIDTH bits]==localAddress.
  - On a reply: latch dataIn and go to RESP with error=0.
  - If the counter reaches TIMEOUT_CYCLES-1 with no reply: go to RESP with error=1 and resp_data=0.
  - If a reply and expiry coincide, the reply wins.
- RESP (one cycle): resp_valid=1, then go to IDLE.
- Discard rule: any valid inbound packet (readIn|writeIn) that is not consumed as a reply in WAIT increments drop_count, which saturates at 255. This covers:
  - packets arriving in IDLE, SEND, or RESP;
  - packets with readIn=1 (including readIn=writeIn=1);
  - replies arriving after a timeout.
- Packets addressed to another node are ignored and not counted.
- All outputs are registered. Packet outputs are 0 outside SEND.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, req_ready=1 after release, all packet outputs 0, resp_valid=0, resp_data=0, resp_error=0, drop_count=0, timeout counter=0.
- Reset mid-transaction aborts it: no response, no packet output. A later reply is counted as dropped.
- Command accepted at edge N → packet outputs valid during cycle N+1 only → req_ready low from N+1 until the transaction completes.
- Store throughput: one per 2 cycles.
- Load: reply sampled at edge M → resp_valid high during cycle M+1 → req_ready=1 in cycle M+2.
- Timeout: resp_valid asserts TIMEOUT_CYCLES+1 cycles after the SEND cycle.
- Inbound inputs are sampled only on rising edges; a packet is one cycle wide.

## Test plan
- Reset: hold reset=0 with random inputs → all outputs 0, req_ready=0 during reset. Release → req_ready=1.
- Store: req_write=1, req_addr={4'd10,3'd1}, req_data=42 → one cycle later writeOut=1, readOut=0, destinationAddressOut={10,1}, requesterAddressOut=localAddress, dataOut=42 for exactly one cycle. No resp_valid. A new command is accepted 2 cycles after the first.
- Load hit: read {10,1}. Three cycles after SEND, inject writeIn=1, destinationAddressIn={localAddress,3'd0}, dataIn=42 → resp_valid=1 with resp_data=42, resp_error=0, exactly one cycle later.
- Timeout: load with no reply → resp_valid=1, resp_error=1, resp_data=0 at TIMEOUT_CYCLES+1 cycles after SEND. Injecting the reply afterwards increments drop_count to 1.
- Coincidence: reply on the expiry edge → resp_error=0 with reply data. A reply in IDLE, a readIn packet, and a packet for another node → drop_count +2 only.
- Mid-operation reset: assert reset during WAIT → no resp_valid; after release, the block is IDLE and accepts a new load normally.
